// File: rtl/sonar_pkg.sv
// -----------------------------------------------------------------------------
// sonar_pkg
// Shared definitions for the ultrasonic ranging path: FSM state encoding of the
// trigger controller and the default sensor timing constants (1 cycle = 1 us).
// Also used by the downstream echo pulse-width counter.
// -----------------------------------------------------------------------------
package sonar_pkg;

    // Default timing, in clk_1m cycles
    localparam int DEF_TRIG_US      = 10;
    localparam int DEF_PERIOD_US    = 60000;
    localparam int DEF_ECHO_WAIT_US = 1000;
    localparam int DEF_ECHO_MAX_US  = 30000;

    // Trigger controller state encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_TRIG      = 3'd1;
    localparam logic [2:0] ST_WAIT_RISE = 3'd2;
    localparam logic [2:0] ST_WAIT_FALL = 3'd3;
    localparam logic [2:0] ST_HOLDOFF   = 3'd4;

endpackage

// File: rtl/echo_sync.sv
// -----------------------------------------------------------------------------
// echo_sync
// Two-flop synchronizer for the asynchronous sensor echo plus registered
// rise/fall strobes. A pin change shows up as a one-cycle strobe three clock
// edges later.
// Ports:
//   clk_1m    in   1 MHz clock
//   rst       in   asynchronous active-high reset
//   echo_i    in   raw echo pin (asynchronous)
//   echo_s_o  out  synchronized echo level
//   rise_o    out  one-cycle strobe on synchronized rising edge
//   fall_o    out  one-cycle strobe on synchronized falling edge
// -----------------------------------------------------------------------------
module echo_sync
    import sonar_pkg::*;
(
    input  logic clk_1m,
    input  logic rst,
    input  logic echo_i,
    output logic echo_s_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       prev_q;
    logic       rise_q;
    logic       fall_q;

    // Synchronizer chain, previous-level flop and registered edge strobes
    always_ff @(posedge clk_1m or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], echo_i};
            prev_q <= sync_q[1];
            rise_q <= sync_q[1] & ~prev_q;
            fall_q <= ~sync_q[1] & prev_q;
        end
    end

    assign echo_s_o = sync_q[1];
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: rtl/sonar_trigger_ctrl.sv
// -----------------------------------------------------------------------------
// sonar_trigger_ctrl
// Issues the periodic trigger pulse to an HC-SR04-class sensor, supervises the
// returning echo and reports each measurement as valid (done) or invalid
// (timeout). Trigger rises are exactly PERIOD_US cycles apart while enabled.
// Ports:
//   clk_1m   in   1 MHz clock
//   rst      in   asynchronous active-high reset
//   enable   in   level, 1 = run periodic measurements
//   echo     in   raw sensor echo (asynchronous)
//   trig     out  sensor trigger, registered
//   busy     out  high from trigger start until the measurement ends
//   done     out  one-cycle pulse, echo fell inside its window
//   timeout  out  one-cycle pulse, echo missing or too long
// -----------------------------------------------------------------------------
module sonar_trigger_ctrl
    import sonar_pkg::*;
#(
    parameter int TRIG_US      = DEF_TRIG_US,
    parameter int PERIOD_US    = DEF_PERIOD_US,
    parameter int ECHO_WAIT_US = DEF_ECHO_WAIT_US,
    parameter int ECHO_MAX_US  = DEF_ECHO_MAX_US
) (
    input  logic clk_1m,
    input  logic rst,
    input  logic enable,
    input  logic echo,
    output logic trig,
    output logic busy,
    output logic done,
    output logic timeout
);

    localparam int CW = $clog2(PERIOD_US + 1);

    // Terminal counts; all comparisons are equality against these
    localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_US - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(ECHO_WAIT_US - 1);
    localparam logic [CW-1:0] MAX_LAST  = CW'(ECHO_MAX_US - 1);
    localparam logic [CW-1:0] PER_LAST  = CW'(PERIOD_US - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic          echo_s;
    logic          echo_rise;
    logic          echo_fall;

    logic [2:0]    state_q,   state_d;
    logic [CW-1:0] per_cnt_q, per_cnt_d;
    logic [CW-1:0] st_cnt_q,  st_cnt_d;
    logic          trig_q,    trig_d;
    logic          busy_q,    busy_d;
    logic          done_q,    done_d;
    logic          timeout_q, timeout_d;

    echo_sync u_echo_sync (
        .clk_1m   (clk_1m),
        .rst      (rst),
        .echo_i   (echo),
        .echo_s_o (echo_s),
        .rise_o   (echo_rise),
        .fall_o   (echo_fall)
    );

    // Next-state and next-output logic of the measurement FSM
    always_comb begin
        state_d   = state_q;
        trig_d    = trig_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A stuck-high echo blocks the next trigger until it drops
                if (enable && !echo_s) begin
                    state_d = ST_TRIG;
                    trig_d  = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TRIG: begin
                if (st_cnt_q == TRIG_LAST) begin
                    state_d = ST_WAIT_RISE;
                    trig_d  = 1'b0;
                end else begin
                    state_d = ST_TRIG;
                end
            end
            ST_WAIT_RISE: begin
                if (echo_rise) begin
                    state_d = ST_WAIT_FALL;
                end else if (st_cnt_q == WAIT_LAST) begin
                    state_d   = ST_HOLDOFF;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_RISE;
                end
            end
            ST_WAIT_FALL: begin
                // Fall is checked first so it wins over the limit in the same cycle
                if (echo_fall) begin
                    state_d = ST_HOLDOFF;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (st_cnt_q == MAX_LAST) begin
                    state_d   = ST_HOLDOFF;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_FALL;
                end
            end
            ST_HOLDOFF: begin
                if (per_cnt_q == PER_LAST) begin
                    if (enable && !echo_s) begin
                        state_d = ST_TRIG;
                        trig_d  = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_HOLDOFF;
                end
            end
            default: begin
                state_d = ST_IDLE;
                trig_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Saturating period and in-state counters
    always_comb begin
        if (state_d != state_q) begin
            st_cnt_d = '0;
        end else if (st_cnt_q == PER_LAST) begin
            st_cnt_d = st_cnt_q;
        end else begin
            st_cnt_d = st_cnt_q + CNT_ONE;
        end

        // Period restarts on every trigger rise
        if ((state_d == ST_TRIG) && (state_q != ST_TRIG)) begin
            per_cnt_d = '0;
        end else if (per_cnt_q == PER_LAST) begin
            per_cnt_d = per_cnt_q;
        end else begin
            per_cnt_d = per_cnt_q + CNT_ONE;
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk_1m or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            per_cnt_q <= '0;
            st_cnt_q  <= '0;
            trig_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            st_cnt_q  <= st_cnt_d;
            trig_q    <= trig_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign trig    = trig_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign timeout = timeout_q;

endmodule
